// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl
// Moore control FSM for a shared-datapath RV32I multicycle core.
// Supported instructions: lw, sw, R-type ALU, I-type ALU, the six branches,
// jal and jalr. Any other encoding enters TRAP, which is left only by reset.
//
// Ports
//   clk              system clock, rising-edge state updates
//   rst_n            synchronous active-low reset
//   i_op             instr[6:0] from the instruction register
//   i_funct3         instr[14:12] from the instruction register
//   i_mem_ready      memory port completes the current access this cycle
//   i_branch_taken   ALU comparator result for the current branch
//   o_pc_write       PC load enable
//   o_adr_src        memory address select: 0 = PC, 1 = ALUOut
//   o_mem_write      store request, held until i_mem_ready
//   o_ir_write       IR / OldPC load enable
//   o_reg_write      register file write enable
//   o_result_src     00 = ALUOut, 01 = read data, 10 = ALU result direct
//   o_alu_src_a      00 = PC, 01 = OldPC, 10 = rs1
//   o_alu_src_b      00 = rs2, 01 = imm, 10 = constant 4
//   o_alu_op         00 = add, 01 = branch compare, 10 = funct-decoded
//   o_imm_src        00 = I, 01 = S, 10 = B, 11 = J
//   o_instr_done     one-cycle pulse in the final state of each instruction
//   o_illegal        sticky flag, set on entry to TRAP
//   o_dbg_state      current FSM state encoding
//
// Handshake: a memory access is in progress for every cycle the FSM sits in
// FETCH, MEMREAD or MEMWRITE; the access completes on the cycle i_mem_ready
// is 1, and only then does the FSM advance (and, for FETCH, load PC/IR).
module rv32i_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_mem_ready,
  input  logic       i_branch_taken,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_imm_src,
  output logic       o_instr_done,
  output logic       o_illegal,
  output logic [3:0] o_dbg_state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_illegal;

  logic        w_pc_write;
  logic        w_adr_src;
  logic        w_mem_write;
  logic        w_ir_write;
  logic        w_reg_write;
  logic [1:0]  w_result_src;
  logic [1:0]  w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic [1:0]  w_alu_op;
  logic [1:0]  w_imm_src;
  logic        w_instr_done;

  // State register and sticky trap flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= state_t'(RESET_STATE);
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Immediate format follows the opcode in every state so the extender is
  // already settled when DECODE computes the branch/jal target.
  always_comb begin
    w_imm_src = 2'b00;
    case (i_op)
      OP_STORE:  w_imm_src = 2'b01;
      OP_BRANCH: w_imm_src = 2'b10;
      OP_JAL:    w_imm_src = 2'b11;
      default:   w_imm_src = 2'b00;
    endcase
  end

  // Next-state and datapath controls.
  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_instr_done = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC + 4 goes straight to the PC while the word is latched into IR.
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = i_mem_ready;
        w_pc_write   = i_mem_ready;
        if (i_mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut for a later branch or jal.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (i_op)
          OP_LOAD:   w_next = (i_funct3 == 3'b010) ? S_MEMADR : S_TRAP;
          OP_STORE:  w_next = (i_funct3 == 3'b010) ? S_MEMADR : S_TRAP;
          OP_RTYPE:  w_next = S_EXEC_R;
          OP_ITYPE:  w_next = S_EXEC_I;
          OP_BRANCH: w_next = (i_funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          OP_JAL:    w_next = S_JAL;
          OP_JALR:   w_next = (i_funct3 == 3'b000) ? S_JALR : S_TRAP;
          default:   w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = (i_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (i_mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (i_mem_ready) begin
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_EXEC_R: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXEC_I: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        // Target already sits in ALUOut; the comparator decides the load.
        w_alu_src_a  = 2'b10;
        w_alu_op     = 2'b01;
        w_pc_write   = i_branch_taken;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JAL: begin
        w_pc_write = 1'b1;
        w_next     = S_LINK;
      end
      S_JALR: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_pc_write   = 1'b1;
        w_next       = S_LINK;
      end
      S_LINK: begin
        // Link value is OldPC + 4, since PC has already been redirected.
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

  // While reset is held every enable is off and every select parks at 00.
  assign o_pc_write   = rst_n & w_pc_write;
  assign o_adr_src    = rst_n & w_adr_src;
  assign o_mem_write  = rst_n & w_mem_write;
  assign o_ir_write   = rst_n & w_ir_write;
  assign o_reg_write  = rst_n & w_reg_write;
  assign o_instr_done = rst_n & w_instr_done;
  assign o_result_src = rst_n ? w_result_src : 2'b00;
  assign o_alu_src_a  = rst_n ? w_alu_src_a  : 2'b00;
  assign o_alu_src_b  = rst_n ? w_alu_src_b  : 2'b00;
  assign o_alu_op     = rst_n ? w_alu_op     : 2'b00;
  assign o_imm_src    = rst_n ? w_imm_src    : 2'b00;
  assign o_illegal    = r_illegal;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl. Each instruction is expanded into the
// per-cycle output pattern its class must produce; that pattern goes into an
// expected queue and one compare process checks the DUT every cycle.
// Instruction lengths observed between instr_done pulses are also pinned
// against hand-computed literals.
module tb_rv32i_multicycle_ctrl;

  localparam int W = 17;

  typedef enum int {C_LW, C_SW, C_R, C_I, C_BR, C_JAL, C_JALR, C_ILL} cls_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] i_op;
  logic [2:0] i_funct3;
  logic       i_mem_ready;
  logic       i_branch_taken;
  logic       o_pc_write;
  logic       o_adr_src;
  logic       o_mem_write;
  logic       o_ir_write;
  logic       o_reg_write;
  logic [1:0] o_result_src;
  logic [1:0] o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [1:0] o_alu_op;
  logic [1:0] o_imm_src;
  logic       o_instr_done;
  logic       o_illegal;
  logic [3:0] o_dbg_state;

  rv32i_multicycle_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_op           (i_op),
    .i_funct3       (i_funct3),
    .i_mem_ready    (i_mem_ready),
    .i_branch_taken (i_branch_taken),
    .o_pc_write     (o_pc_write),
    .o_adr_src      (o_adr_src),
    .o_mem_write    (o_mem_write),
    .o_ir_write     (o_ir_write),
    .o_reg_write    (o_reg_write),
    .o_result_src   (o_result_src),
    .o_alu_src_a    (o_alu_src_a),
    .o_alu_src_b    (o_alu_src_b),
    .o_alu_op       (o_alu_op),
    .o_imm_src      (o_imm_src),
    .o_instr_done   (o_instr_done),
    .o_illegal      (o_illegal),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [W-1:0] exp_q[$];
  int           n_tests;
  int           n_fail;
  logic [6:0]   g_op;
  logic [2:0]   g_f3;
  logic         m_illegal;
  int           cyc_cnt;
  int           last_len;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic cls_t cls_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return (f3 == 3'd2) ? C_LW : C_ILL;
      7'b0100011: return (f3 == 3'd2) ? C_SW : C_ILL;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? C_ILL : C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return (f3 == 3'd0) ? C_JALR : C_ILL;
      default:    return C_ILL;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One cycle: apply inputs just after the rising edge and queue the outputs
  // this cycle must show. Vector order:
  // {pc, adr, mw, ir, rw, res, a, b, alu, imm, done, illegal}
  task automatic cyc(input logic rst, input logic mr, input logic bt,
                     input logic pc, input logic adr, input logic mw,
                     input logic ir, input logic rw, input logic [1:0] res,
                     input logic [1:0] a, input logic [1:0] b,
                     input logic [1:0] alu, input logic done);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    rst_n          = rst;
    i_op           = g_op;
    i_funct3       = g_f3;
    i_mem_ready    = mr;
    i_branch_taken = bt;
    if (!rst) begin
      e = {16'h0, m_illegal};
      m_illegal = 1'b0;
    end else begin
      e = {pc, adr, mw, ir, rw, res, a, b, alu, imm_of(g_op), done, m_illegal};
    end
    exp_q.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input int n);
    repeat (n) cyc(1'b0, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endtask

  task automatic fetch(input int w);
    repeat (w) cyc(1'b1, 1'b0, rb(), 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    cyc(1'b1, 1'b1, rb(), 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
  endtask

  task automatic decode();
    cyc(1'b1, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
  endtask

  // Full instruction from FETCH to retirement (or into TRAP for trap_cycles).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input int wf, input int wm, input logic taken,
                           input int trap_cycles);
    cls_t c;
    g_op = op;
    g_f3 = f3;
    c = cls_of(op, f3);
    fetch(wf);
    decode();
    case (c)
      C_LW: begin
        cyc(1'b1, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        repeat (wm) cyc(1'b1, 1'b0, rb(), 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        cyc(1'b1, 1'b1, rb(), 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        cyc(1'b1, rb(), rb(), 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1);
      end
      C_SW: begin
        cyc(1'b1, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        repeat (wm) cyc(1'b1, 1'b0, rb(), 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        cyc(1'b1, 1'b1, rb(), 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      end
      C_R, C_I: begin
        cyc(1'b1, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10,
            (c == C_I) ? 2'b01 : 2'b00, 2'b10, 0);
        cyc(1'b1, rb(), rb(), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      end
      C_BR: begin
        cyc(1'b1, rb(), taken, taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1);
      end
      C_JAL, C_JALR: begin
        if (c == C_JAL)
          cyc(1'b1, rb(), rb(), 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        else
          cyc(1'b1, rb(), rb(), 1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b00, 0);
        cyc(1'b1, rb(), rb(), 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 2'b00, 1);
      end
      default: begin
        m_illegal = 1'b1;
        repeat (trap_cycles)
          cyc(1'b1, rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    act = {o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_reg_write,
           o_result_src, o_alu_src_a, o_alu_src_b, o_alu_op, o_imm_src,
           o_instr_done, o_illegal};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t op=%b f3=%b rst_n=%b got=%b exp=%b (pc,adr,mw,ir,rw,res,a,b,alu,imm,done,ill)",
                 $time, i_op, i_funct3, rst_n, act, e);
      end
    end
    if (rst_n !== 1'b1) begin
      cyc_cnt = 0;
    end else begin
      cyc_cnt++;
      if (o_instr_done === 1'b1) begin
        last_len = cyc_cnt;
        cyc_cnt  = 0;
      end
    end
  end

  // Literal check on the length of the instruction that just retired.
  task automatic check_len(input string name, input int want);
    @(negedge clk);
    #1;
    n_tests++;
    if (last_len != want) begin
      n_fail++;
      $display("FAIL len_%s got=%0d exp=%0d", name, last_len, want);
    end
  endtask

  task automatic check_illegal(input string name, input logic want);
    @(negedge clk);
    #1;
    n_tests++;
    if (o_illegal !== want) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, o_illegal, want);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int         k;
    logic [6:0] ill_ops[4];
    n_tests   = 0;
    n_fail    = 0;
    m_illegal = 1'b0;
    cyc_cnt   = 0;
    last_len  = 0;
    g_op      = 7'b0110011;
    g_f3      = 3'd0;
    rst_n          = 1'b0;
    i_op           = g_op;
    i_funct3       = g_f3;
    i_mem_ready    = 1'b1;
    i_branch_taken = 1'b0;
    ill_ops[0] = 7'b0110111;
    ill_ops[1] = 7'b0010111;
    ill_ops[2] = 7'b0000000;
    ill_ops[3] = 7'b1110011;

    // Reset: three cycles low with mem_ready high; the first edge settles state.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_mem_ready = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);

    // Directed instructions, each pinned to its known cycle count.
    run_instr(7'b0110011, 3'd0, 0, 0, 1'b0, 0); check_len("r_type", 4);
    run_instr(7'b0000011, 3'd2, 0, 2, 1'b0, 0); check_len("lw_wait2", 7);
    run_instr(7'b0000011, 3'd2, 0, 0, 1'b0, 0); check_len("lw", 5);
    run_instr(7'b0100011, 3'd2, 0, 0, 1'b0, 0); check_len("sw", 4);
    run_instr(7'b1100011, 3'd0, 0, 0, 1'b1, 0); check_len("beq_taken", 3);
    run_instr(7'b1100011, 3'd0, 0, 0, 1'b0, 0); check_len("beq_not_taken", 3);
    run_instr(7'b1101111, 3'd5, 0, 0, 1'b0, 0); check_len("jal", 4);
    run_instr(7'b1100111, 3'd0, 0, 0, 1'b0, 0); check_len("jalr", 4);
    run_instr(7'b0010011, 3'd4, 1, 0, 1'b0, 0); check_len("i_type_fetch_wait", 5);
    run_instr(7'b0100011, 3'd2, 2, 1, 1'b0, 0); check_len("sw_waits", 7);

    // LUI traps; mem_ready activity does not release it, only reset does.
    run_instr(7'b0110111, 3'd0, 0, 0, 1'b0, 10);
    check_illegal("illegal_sticky", 1'b1);
    do_reset(2);
    check_illegal("illegal_cleared", 1'b0);
    run_instr(7'b0110011, 3'd7, 0, 0, 1'b0, 0); check_len("after_trap", 4);

    // Reset in the middle of a load's memory wait, then a clean restart.
    g_op = 7'b0000011;
    g_f3 = 3'd2;
    fetch(0);
    decode();
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    do_reset(2);
    run_instr(7'b1100011, 3'd1, 0, 0, 1'b1, 0); check_len("bne_after_reset", 3);

    // Randomised instruction stream.
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 12);
      f3 = 3'($urandom_range(0, 7));
      case (k)
        0, 1: begin op = 7'b0000011; f3 = 3'd2; end
        2, 3: begin op = 7'b0100011; f3 = 3'd2; end
        4:    op = 7'b0110011;
        5:    op = 7'b0010011;
        6, 7: begin
          op = 7'b1100011;
          if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 + 3'd2;
        end
        8:    op = 7'b1101111;
        9:    begin op = 7'b1100111; f3 = 3'd0; end
        10:   begin op = 7'b0000011; if (f3 == 3'd2) f3 = 3'd3; end
        11:   begin op = 7'b1100111; if (f3 == 3'd0) f3 = 3'd1; end
        default: op = ill_ops[$urandom_range(0, 3)];
      endcase
      run_instr(op, f3, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                $urandom_range(1, 4));
      if (cls_of(op, f3) == C_ILL) begin
        do_reset($urandom_range(1, 3));
      end
    end

    // Drain the last queued expectation.
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
Moore-style control FSM that sequences the shared RV32I multicycle datapath. The datapath has one memory port, one ALU, instruction/data/ALUOut registers and the immediate sign-extend unit. Each cycle the block decodes op/funct3 and drives the mux selects, register-write enables, memory handshake and imm_src for the extender. It sits between the instruction register and the datapath muxes. Supported subset is lw, sw, R-type ALU, I-type ALU, the six branches, jal and jalr; any other instruction traps.

Parameters:
RESET_STATE, 4'd0, state encoding of FETCH, loaded on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12] from instruction register
mem_ready  input  1  memory port completes the current access this cycle
branch_taken  input  1  ALU comparator result for the current branch
pc_write  output  1  PC register load enable
adr_src  output  1  memory address: 0 = PC, 1 = ALUOut
mem_write  output  1  store request, held until mem_ready
ir_write  output  1  instruction register (and OldPC) load enable
reg_write  output  1  register file write enable
result_src  output  2  00 = ALUOut, 01 = read data, 10 = ALU result direct
alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1
alu_src_b  output  2  00 = rs2, 01 = imm, 10 = constant 4
alu_op  output  2  00 = add, 01 = branch compare, 10 = funct-decoded
imm_src  output  2  00 = I, 01 = S, 10 = B, 11 = J
instr_done  output  1  one-cycle pulse in the final state of each retired instruction
illegal  output  1  sticky: set on entry to TRAP

Behaviour:
- Reset: rst_n low at a rising edge puts the state in FETCH and clears illegal. While rst_n is low, all enables (pc_write, mem_write, ir_write, reg_write, instr_done) are forced 0. Mux selects are 00.
- Reset mid-instruction: any write already committed stays committed. No partial hold-over state survives reset.
- Outputs are decoded combinationally from state only. op, funct3 and branch_taken/mem_ready gate where listed. Unlisted outputs are 0.
- imm_src comes from op in every state: store 01, branch 10, jal 11, all others 00.
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - ir_write and pc_write assert only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; on mem_ready=1 goes to DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch/jal target into ALUOut). Next state by op:
  - 0000011 with funct3=010, or 0100011 with funct3=010 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 with funct3 not 010/011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 with funct3=000 -> JALR
  - anything else -> TRAP
- MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adr_src=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Then FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held every cycle until mem_ready=1. On that cycle instr_done=1 and next state is FETCH.
- EXEC_R: a=10, b=00, alu_op=10. Then ALUWB.
- EXEC_I: a=10, b=01, alu_op=10. Then ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Then FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write=branch_taken, instr_done=1. Then FETCH.
- JAL: result_src=00, pc_write=1. Then LINK.
- JALR: a=10, b=01, alu_op=00, result_src=10, pc_write=1. Then LINK. Clearing the target LSB is the datapath's job.
- LINK: a=01, b=10, alu_op=00, result_src=10, reg_write=1, instr_done=1. Then FETCH.
- TRAP: terminal until reset. All enables 0, illegal=1.
- Cycle counts with zero wait states:
  - lw: 5
  - sw: 4
  - R-type / I-type: 4
  - branch: 3
  - jal / jalr: 4
- Each wait cycle on a memory access adds exactly 1 cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> every enable 0 and illegal=0; the first cycle after release is FETCH with ir_write=pc_write=1.
- lw with wait states: op=0000011, funct3=010, mem_ready=0 for 2 cycles in MEMREAD -> adr_src=1 held for 3 cycles; reg_write=1 with result_src=01 exactly 1 cycle later; instruction total 7 cycles.
- sw: op=0100011, funct3=010, mem_ready=1 -> imm_src=01 throughout; mem_write=1 for exactly 1 cycle; reg_write never asserts; instr_done in cycle 4.
- Branch: op=1100011, funct3=000, branch_taken=1 then a second beq with branch_taken=0 -> pc_write=1 in BRANCH for the first, 0 for the second; imm_src=10; both retire in 3 cycles.
- jal: op=1101111 -> imm_src=11; pc_write with result_src=00 in cycle 3; reg_write with a=01, b=10, result_src=10 in cycle 4.
- Illegal: op=0110111 (LUI), then mem_ready toggling for 10 cycles -> illegal=1 from the cycle after DECODE and all enables stay 0; only rst_n=0 returns the FSM to FETCH with illegal=0.
